// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave among N_MASTERS IOb masters.
// One transaction in flight; grant is held until write acceptance or read data return.
module iob_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int GNT_W    = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          arst_i,

    input  logic [N_MASTERS-1:0]          m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb_i,
    output logic [N_MASTERS-1:0]          m_ready_o,
    output logic [N_MASTERS-1:0]          m_rvalid_o,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,

    output logic                          s_avalid_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic [STRB_W-1:0]             s_wstrb_o,
    input  logic                          s_ready_i,
    input  logic                          s_rvalid_i,
    input  logic [DATA_W-1:0]             s_rdata_i,

    output logic [GNT_W-1:0]              grant_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDATA
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GNT_W-1:0]   r_grant;
    logic [GNT_W-1:0]   w_grant_nxt;
    logic [GNT_W-1:0]   r_rr_ptr;
    logic [GNT_W-1:0]   w_rr_ptr_nxt;
    logic [GNT_W-1:0]   w_pick;
    logic [GNT_W-1:0]   w_grant_inc;
    logic               w_found;
    logic               w_sel_avalid;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [STRB_W-1:0]  w_sel_wstrb;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else if (cke_i) begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // First requester at or after r_rr_ptr, wrapping modulo N_MASTERS.
    always_comb begin
        int unsigned v_idx;
        w_pick  = '0;
        w_found = 1'b0;
        v_idx   = 0;
        for (int unsigned j = 0; j < N_MASTERS; j++) begin
            v_idx = int'(r_rr_ptr) + j;
            if (v_idx >= N_MASTERS) begin
                v_idx = v_idx - N_MASTERS;
            end
            for (int unsigned k = 0; k < N_MASTERS; k++) begin
                if (!w_found && k == v_idx && m_avalid_i[k]) begin
                    w_found = 1'b1;
                    w_pick  = GNT_W'(k);
                end
            end
        end
    end

    always_comb begin
        w_sel_avalid = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_wstrb  = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (GNT_W'(k) == r_grant) begin
                w_sel_avalid = m_avalid_i[k];
                w_sel_addr   = m_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata  = m_wdata_i[k*DATA_W +: DATA_W];
                w_sel_wstrb  = m_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign w_grant_inc = (r_grant == GNT_W'(N_MASTERS - 1)) ? '0 : r_grant + 1'b1;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state != IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        s_avalid_o   = 1'b0;
        s_addr_o     = '0;
        s_wdata_o    = '0;
        s_wstrb_o    = '0;
        m_ready_o    = '0;
        m_rvalid_o   = '0;
        m_rdata_o    = '0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                s_avalid_o = w_sel_avalid;
                s_addr_o   = w_sel_addr;
                s_wdata_o  = w_sel_wdata;
                s_wstrb_o  = w_sel_wstrb;
                for (int unsigned k = 0; k < N_MASTERS; k++) begin
                    if (GNT_W'(k) == r_grant) begin
                        m_ready_o[k] = s_ready_i;
                    end
                end
                // A withdrawn request abandons the slot without advancing the pointer.
                if (!w_sel_avalid) begin
                    w_state_nxt = IDLE;
                end else if (s_ready_i) begin
                    if (w_sel_wstrb != '0) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_grant_inc;
                    end else begin
                        w_state_nxt = RDATA;
                    end
                end
            end
            RDATA: begin
                for (int unsigned k = 0; k < N_MASTERS; k++) begin
                    if (GNT_W'(k) == r_grant) begin
                        m_rvalid_o[k]                   = s_rvalid_i;
                        m_rdata_o[k*DATA_W +: DATA_W]   = s_rdata_i;
                    end
                end
                if (s_rvalid_i) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Self-checking bench for iob_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_iob_rr_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic               clk_i = 1'b0;
    logic               cke_i;
    logic               arst_i;
    logic [NM-1:0]      m_avalid_i;
    logic [NM*AW-1:0]   m_addr_i;
    logic [NM*DW-1:0]   m_wdata_i;
    logic [NM*SW-1:0]   m_wstrb_i;
    logic [NM-1:0]      m_ready_o;
    logic [NM-1:0]      m_rvalid_o;
    logic [NM*DW-1:0]   m_rdata_o;
    logic               s_avalid_o;
    logic [AW-1:0]      s_addr_o;
    logic [DW-1:0]      s_wdata_o;
    logic [SW-1:0]      s_wstrb_o;
    logic               s_ready_i;
    logic               s_rvalid_i;
    logic [DW-1:0]      s_rdata_i;
    logic [0:0]         grant_o;
    logic               busy_o;

    iob_rr_arbiter #(.N_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_wstrb_i(m_wstrb_i), .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_ready_i(s_ready_i),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .grant_o(grant_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the slave, whether it is waiting for read data,
    // and which master gets first look at the next arbitration.
    bit md_idle = 1'b1;
    bit md_rd   = 1'b0;
    int md_gnt  = 0;
    int md_ptr  = 0;
    bit acc[NM];

    task automatic model_reset();
        md_idle = 1'b1;
        md_rd   = 1'b0;
        md_gnt  = 0;
        md_ptr  = 0;
    endtask

    task automatic model_step();
        if (!cke_i || arst_i) return;
        if (md_idle) begin
            for (int j = NM - 1; j >= 0; j--) begin
                if (m_avalid_i[(md_ptr + j) % NM]) begin
                    md_gnt  = (md_ptr + j) % NM;
                    md_idle = 1'b0;
                    md_rd   = 1'b0;
                end
            end
        end else if (!md_rd) begin
            if (!m_avalid_i[md_gnt]) begin
                md_idle = 1'b1;
            end else if (s_ready_i) begin
                if (m_wstrb_i[md_gnt*SW +: SW] != 0) begin
                    md_idle = 1'b1;
                    md_ptr  = (md_gnt + 1) % NM;
                end else begin
                    md_rd = 1'b1;
                end
            end
        end else if (s_rvalid_i) begin
            md_idle = 1'b1;
            md_rd   = 1'b0;
            md_ptr  = (md_gnt + 1) % NM;
        end
    endtask

    task automatic compare_all();
        logic          e_sav;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [SW-1:0] e_ws;
        logic [NM-1:0] e_rdy;
        logic [NM-1:0] e_rv;
        logic [NM*DW-1:0] e_rd;
        e_sav = 1'b0; e_addr = '0; e_wd = '0; e_ws = '0;
        e_rdy = '0; e_rv = '0; e_rd = '0;
        if (!md_idle && !md_rd) begin
            e_sav         = m_avalid_i[md_gnt];
            e_addr        = m_addr_i[md_gnt*AW +: AW];
            e_wd          = m_wdata_i[md_gnt*DW +: DW];
            e_ws          = m_wstrb_i[md_gnt*SW +: SW];
            e_rdy[md_gnt] = s_ready_i;
        end else if (!md_idle) begin
            e_rv[md_gnt]            = s_rvalid_i;
            e_rd[md_gnt*DW +: DW]   = s_rdata_i;
        end
        chk("s_avalid", 64'(s_avalid_o), 64'(e_sav));
        chk("s_addr",   64'(s_addr_o),   64'(e_addr));
        chk("s_wdata",  64'(s_wdata_o),  64'(e_wd));
        chk("s_wstrb",  64'(s_wstrb_o),  64'(e_ws));
        chk("m_ready",  64'(m_ready_o),  64'(e_rdy));
        chk("m_rvalid", 64'(m_rvalid_o), 64'(e_rv));
        chk("m_rdata",  64'(m_rdata_o),  64'(e_rd));
        chk("grant",    64'(grant_o),    64'(md_gnt));
        chk("busy",     64'(busy_o),     64'(!md_idle));
        for (int k = 0; k < NM; k++) acc[k] = e_rdy[k] & m_avalid_i[k] & cke_i & !arst_i;
    endtask

    task automatic cyc();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        #2;
        model_reset();
        compare_all();
        arst_i = 1'b0;
    endtask

    logic          rq[NM];
    logic [AW-1:0] ra[NM];
    logic [DW-1:0] rw[NM];
    logic [SW-1:0] rs[NM];

    task automatic new_req(input int k);
        rq[k] = 1'b1;
        ra[k] = $urandom;
        rw[k] = $urandom;
        rs[k] = ($urandom_range(0, 1) != 0) ? SW'($urandom_range(1, 15)) : '0;
    endtask

    int gseq;
    int nrdy[NM];

    initial begin
        cke_i = 1'b1; arst_i = 1'b1;
        m_avalid_i = '0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
        s_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        model_reset();
        @(negedge clk_i);
        compare_all();
        arst_i = 1'b0;
        @(posedge clk_i); #1;

        // Single write from master 1
        m_avalid_i = 2'b10; m_addr_i[63:32] = 32'h40; m_wdata_i[63:32] = 32'hDEADBEEF;
        m_wstrb_i[7:4] = 4'hF; s_ready_i = 1'b1;
        cyc(); chk("w1_idle_sav", 64'(s_avalid_o), 0); adv();
        cyc(); chk("w1_sav", 64'(s_avalid_o), 1); chk("w1_addr", 64'(s_addr_o), 64'h40);
        chk("w1_rdy", 64'(m_ready_o), 64'b10); adv();
        m_avalid_i = '0;
        cyc(); chk("w1_done_busy", 64'(busy_o), 0); chk("w1_gnt_kept", 64'(grant_o), 1); adv();

        // Single read from master 0, data three cycles after acceptance
        m_avalid_i = 2'b01; m_addr_i[31:0] = 32'h80; m_wstrb_i = '0;
        cyc(); adv();
        cyc(); chk("r0_rdy", 64'(m_ready_o), 64'b01); adv();
        m_avalid_i = '0;
        for (int i = 0; i < 3; i++) begin
            s_rvalid_i = (i == 2);
            s_rdata_i  = (i == 2) ? 32'h12345678 : 32'hBAD00000 + 32'(i);
            cyc();
            chk("r0_busy", 64'(busy_o), 1);
            chk("r0_rv", 64'(m_rvalid_o), (i == 2) ? 64'b01 : 64'b00);
            if (i == 2) chk("r0_rdata", 64'(m_rdata_o[31:0]), 64'h12345678);
            adv();
        end
        s_rvalid_i = 1'b0;

        // Contention: both masters stream writes
        do_reset(); cyc(); adv();
        m_avalid_i = 2'b11; m_addr_i = {32'h200, 32'h100}; m_wstrb_i = 8'hFF;
        s_ready_i = 1'b1; gseq = 0; nrdy[0] = 0; nrdy[1] = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (!md_idle) begin
                chk("cont_gnt", 64'(grant_o), 64'(gseq));
                gseq ^= 1;
            end
            for (int k = 0; k < NM; k++) if (m_ready_o[k]) nrdy[k]++;
            adv();
        end
        chk("cont_rdy0", 64'(nrdy[0]), 2);
        chk("cont_rdy1", 64'(nrdy[1]), 2);
        m_avalid_i = '0;
        cyc(); adv();

        // Backpressure in REQ
        m_avalid_i = 2'b01; m_addr_i[31:0] = 32'h12345670; m_wdata_i[31:0] = 32'hCAFEF00D;
        m_wstrb_i = 8'h0F; s_ready_i = 1'b0;
        cyc(); adv();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_sav", 64'(s_avalid_o), 1);
            chk("bp_addr", 64'(s_addr_o), 64'h12345670);
            chk("bp_wdata", 64'(s_wdata_o), 64'hCAFEF00D);
            chk("bp_rdy", 64'(m_ready_o), 0);
            chk("bp_gnt", 64'(grant_o), 0);
            adv();
        end
        s_ready_i = 1'b1;
        cyc(); chk("bp_rdy_final", 64'(m_ready_o), 64'b01); adv();
        m_avalid_i = '0;

        // Reset while waiting for read data; the late response must be dropped
        m_avalid_i = 2'b01; m_wstrb_i = '0; s_ready_i = 1'b1;
        cyc(); adv();
        cyc(); adv();
        m_avalid_i = '0; s_ready_i = 1'b0;
        cyc(); chk("rst_in_rdata", 64'(busy_o), 1); adv();
        do_reset();
        s_rvalid_i = 1'b1; s_rdata_i = 32'h55AA55AA;
        cyc(); chk("rst_late_rv", 64'(m_rvalid_o), 0); chk("rst_late_rd", 64'(m_rdata_o), 0); adv();
        s_rvalid_i = 1'b0; m_avalid_i = 2'b01; m_wstrb_i = 8'h0F; s_ready_i = 1'b1;
        cyc(); adv();
        cyc(); chk("rst_next_gnt", 64'(grant_o), 0); chk("rst_next_rdy", 64'(m_ready_o), 64'b01); adv();
        m_avalid_i = '0;

        // Clock enable low while stalled in REQ
        m_avalid_i = 2'b10; m_wstrb_i = 8'hF0; s_ready_i = 1'b0;
        cyc(); adv();
        cyc(); adv();
        cke_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ce_busy", 64'(busy_o), 1);
            chk("ce_gnt", 64'(grant_o), 1);
            chk("ce_sav", 64'(s_avalid_o), 1);
            adv();
        end
        cke_i = 1'b1; s_ready_i = 1'b1;
        cyc(); chk("ce_rdy", 64'(m_ready_o), 64'b10); adv();
        m_avalid_i = '0;
        cyc(); chk("ce_done", 64'(busy_o), 0); adv();

        // Random traffic
        for (int k = 0; k < NM; k++) begin
            rq[k] = 1'b0; acc[k] = 1'b0; ra[k] = '0; rw[k] = '0; rs[k] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NM; k++) begin
                if (acc[k]) begin
                    if ($urandom_range(0, 2) != 0) new_req(k);
                    else rq[k] = 1'b0;
                end else if (!rq[k]) begin
                    if ($urandom_range(0, 2) == 0) new_req(k);
                end else if ($urandom_range(0, 63) == 0) begin
                    rq[k] = 1'b0;
                end
                m_avalid_i[k]           = rq[k];
                m_addr_i[k*AW +: AW]    = ra[k];
                m_wdata_i[k*DW +: DW]   = rw[k];
                m_wstrb_i[k*SW +: SW]   = rs[k];
            end
            s_ready_i  = ($urandom_range(0, 2) != 0);
            s_rvalid_i = ($urandom_range(0, 3) == 0);
            s_rdata_i  = $urandom;
            cke_i      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iob_rr_arbiter.md
Name: iob_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream IOb slave interface among N_MASTERS upstream IOb masters. Typical downstream: an APB-bridged peripheral cluster.
- One outstanding transaction at a time. The grant is held until the transaction completes:
  - write: request accepted;
  - read: read data returned.
- Upstream ports are flattened; master k occupies bit slice k of every bus.

Parameters:
- N_MASTERS, 2, number of upstream masters (>=2). Grant index width GNT_W = max(1, clog2(N_MASTERS)).
- ADDR_W, 32, IOb address width.
- DATA_W, 32, IOb data width (multiple of 8).

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all registers hold when 0.
- arst_i  in  1  asynchronous active-high reset.
- m_avalid_i  in  N_MASTERS  per-master request valid.
- m_addr_i  in  N_MASTERS*ADDR_W  per-master address.
- m_wdata_i  in  N_MASTERS*DATA_W  per-master write data.
- m_wstrb_i  in  N_MASTERS*DATA_W/8  per-master write strobe; 0 means read.
- m_ready_o  out  N_MASTERS  per-master request accepted.
- m_rvalid_o  out  N_MASTERS  per-master read data valid.
- m_rdata_o  out  N_MASTERS*DATA_W  per-master read data.
- s_avalid_o  out  1  downstream request valid.
- s_addr_o  out  ADDR_W  downstream address.
- s_wdata_o  out  DATA_W  downstream write data.
- s_wstrb_o  out  DATA_W/8  downstream write strobe.
- s_ready_i  in  1  downstream accepts request.
- s_rvalid_i  in  1  downstream read data valid.
- s_rdata_i  in  DATA_W  downstream read data.
- grant_o  out  GNT_W  index of the current/last granted master.
- busy_o  out  1  high in states REQ and RDATA.

Behaviour:
- Reset (arst_i=1, async): state=IDLE, grant=0, rr_ptr=0. All outputs are 0 while in IDLE.
- Round-robin pick: the first index i with m_avalid_i[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_MASTERS.
- State IDLE:
  - s_avalid_o=0; all m_ready_o=0; all m_rvalid_o=0.
  - If any m_avalid_i is set: grant <= pick, state <= REQ.
  - Arbitration latency is 1 cycle.
- State REQ:
  - s_avalid_o = m_avalid_i[grant]. s_addr_o, s_wdata_o, s_wstrb_o are muxed from slice grant.
  - m_ready_o[grant] = s_ready_i; all other m_ready_o bits are 0.
  - On s_avalid_o & s_ready_i:
    - wstrb != 0 (write): state <= IDLE, rr_ptr <= (grant+1) mod N_MASTERS.
    - wstrb == 0 (read): state <= RDATA.
  - If m_avalid_i[grant] drops before acceptance (protocol violation): state <= IDLE, rr_ptr unchanged.
- State RDATA:
  - s_avalid_o=0.
  - m_rvalid_o[grant] = s_rvalid_i; m_rdata_o slice grant = s_rdata_i; other slices are 0.
  - On s_rvalid_i: state <= IDLE, rr_ptr <= (grant+1) mod N_MASTERS.
  - Read-data latency is unbounded; there is no timeout.
- Data-path outputs in IDLE: s_addr_o/s_wdata_o/s_wstrb_o are 0 and all m_rdata_o slices are 0.
- Throughput:
  - write: minimum 2 cycles per transaction (IDLE + REQ with same-cycle ready);
  - read: minimum 3 cycles per transaction.
- A non-granted master holding m_avalid_i sees m_ready_o=0 until granted. Requests are never dropped.
- Fairness: any continuously requesting master is granted within N_MASTERS transactions.
- s_rvalid_i arriving outside RDATA is ignored and not routed.
- cke_i=0 freezes state, grant and rr_ptr. Combinational outputs still follow the frozen state.
- Reset mid-transaction returns immediately to IDLE. A read response that later arrives in IDLE is discarded.
- grant_o retains its last value in IDLE. busy_o = (state != IDLE).

Test Plan:
- Single write, master 1:
  - Stimulus: m_avalid_i=2'b10, addr=0x40, wdata=0xDEADBEEF, wstrb=4'hF, s_ready_i=1.
  - Response: cycle 1 s_avalid_o=1 with s_addr_o=0x40; m_ready_o=2'b10 in the same cycle; IDLE on cycle 2; rr_ptr=0.
- Single read, master 0:
  - Stimulus: s_ready_i=1; s_rvalid_i asserted 3 cycles after acceptance with s_rdata_i=0x12345678.
  - Response: m_rvalid_o=2'b01 and m_rdata_o[31:0]=0x12345678 exactly in that cycle; busy_o=1 throughout.
- Contention:
  - Stimulus: both masters request writes continuously, s_ready_i=1.
  - Response: grant_o sequence 0,1,0,1; each master receives one m_ready_o per 4 cycles.
- Backpressure:
  - Stimulus: s_ready_i=0 for 5 cycles during REQ.
  - Response: s_avalid_o, s_addr_o and s_wdata_o stable; m_ready_o=0; no grant change.
- Reset during RDATA:
  - Stimulus: assert arst_i, then deliver s_rvalid_i=1 after release.
  - Response: all outputs 0; m_rvalid_o stays 0; the next request from master 0 is granted normally.
- Clock enable:
  - Stimulus: cke_i=0 for 4 cycles in REQ with s_ready_i=0.
  - Response: state and grant_o frozen; the transaction resumes and completes after cke_i=1.
